// File: rtl/bfs_level_scheduler_if.sv
// Engine command/status bundle between the BFS run sequencer and the traversal engine.
// master: sequencer side (drives commands, frontier select); slave: engine side.
// Command channel is valid/ready; op_done, next_frontier_cnt and edge_visited are engine-driven pulses.
interface bfs_level_scheduler_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 16
);
  logic                   eng_cmd_valid;
  logic                   eng_cmd_ready;
  logic [1:0]             eng_cmd_op;
  logic [DATA_WIDTH-1:0]  eng_cmd_node;
  logic [DATA_WIDTH-1:0]  eng_cmd_base;
  logic [LEVEL_WIDTH-1:0] eng_cmd_level;
  logic                   eng_frontier_sel;
  logic                   eng_op_done;
  logic [DATA_WIDTH-1:0]  eng_next_frontier_cnt;
  logic                   eng_edge_visited;

  modport master (
    output eng_cmd_valid, eng_cmd_op, eng_cmd_node, eng_cmd_base, eng_cmd_level, eng_frontier_sel,
    input  eng_cmd_ready, eng_op_done, eng_next_frontier_cnt, eng_edge_visited
  );

  modport slave (
    input  eng_cmd_valid, eng_cmd_op, eng_cmd_node, eng_cmd_base, eng_cmd_level, eng_frontier_sel,
    output eng_cmd_ready, eng_op_done, eng_next_frontier_cnt, eng_edge_visited
  );
endinterface

// File: rtl/bfs_level_scheduler.sv
// BFS run sequencer: start edge -> INIT, one LEVEL per frontier, FLUSH, then done/error status.
// Latency: busy/command 1 cycle after start edge; 1-cycle CHECK between a level's done and the next command.
// Backpressure: command fields held stable while eng_cmd_valid and !eng_cmd_ready; exactly one handshake per command.
// Ports: clk/rst_n; CSR side start, start_node_address, graph_base_address, busy, done, error,
//        incr_traversed_edges, level_count; engine side via bfs_level_scheduler_if.master (eng_if).
// Optional: define BFS_SCHED_TIMEOUT_EN for a per-WAIT watchdog of TIMEOUT_CYCLES cycles.
module bfs_level_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int LEVEL_WIDTH = 16,
  parameter logic [LEVEL_WIDTH-1:0] MAX_LEVELS = 16'hFFFF
`ifdef BFS_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  start_node_address,
  input  logic [DATA_WIDTH-1:0]  graph_base_address,
  bfs_level_scheduler_if.master  eng_if,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   incr_traversed_edges,
  output logic [LEVEL_WIDTH-1:0] level_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_CMD, S_INIT_WAIT, S_LVL_CMD, S_LVL_WAIT,
    S_CHECK, S_FLUSH_CMD, S_FLUSH_WAIT, S_FIN
  } state_t;

  localparam logic [1:0] OP_INIT  = 2'd0;
  localparam logic [1:0] OP_LEVEL = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;

  state_t                 state, state_nxt;
  logic                   start_q;
  logic                   start_edge;
  logic [DATA_WIDTH-1:0]  node_q;
  logic [DATA_WIDTH-1:0]  base_q;
  logic [DATA_WIDTH-1:0]  cnt_q;
  logic                   frontier_sel;
  logic [LEVEL_WIDTH-1:0] lvl_inc;
  logic                   cap_hit;
  logic                   in_wait;
  logic                   timeout_hit;
  logic                   cmd_valid;
  logic [1:0]             cmd_op;

  assign start_edge = start & ~start_q;
  assign in_wait    = (state == S_INIT_WAIT) || (state == S_LVL_WAIT) || (state == S_FLUSH_WAIT);

  // Saturating increment so level_count can never wrap, even with MAX_LEVELS at all-ones.
  assign lvl_inc = (level_count == {LEVEL_WIDTH{1'b1}}) ? level_count : level_count + 1'b1;
  // An empty next frontier is a normal finish and takes priority over the level cap.
  assign cap_hit = (cnt_q != '0) && (lvl_inc == MAX_LEVELS);

`ifdef BFS_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside WAIT states, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tmo_cnt <= '0;
    else if (!in_wait) tmo_cnt <= '0;
    else               tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A done pulse in the final allowed cycle still wins over the watchdog.
  assign timeout_hit = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !eng_if.eng_op_done;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    cmd_op    = OP_INIT;
    case (state)
      S_IDLE:       if (start_edge) state_nxt = S_INIT_CMD;
      S_INIT_CMD: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_INIT;
        if (eng_if.eng_cmd_ready) state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (timeout_hit)             state_nxt = S_FIN;
        else if (eng_if.eng_op_done) state_nxt = S_LVL_CMD;
      end
      S_LVL_CMD: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_LEVEL;
        if (eng_if.eng_cmd_ready) state_nxt = S_LVL_WAIT;
      end
      S_LVL_WAIT: begin
        if (timeout_hit)             state_nxt = S_FIN;
        else if (eng_if.eng_op_done) state_nxt = S_CHECK;
      end
      S_CHECK:      state_nxt = ((cnt_q == '0) || cap_hit) ? S_FLUSH_CMD : S_LVL_CMD;
      S_FLUSH_CMD: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_FLUSH;
        if (eng_if.eng_cmd_ready) state_nxt = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (timeout_hit)             state_nxt = S_FIN;
        else if (eng_if.eng_op_done) state_nxt = S_FIN;
      end
      S_FIN:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q              <= 1'b0;
      node_q               <= '0;
      base_q               <= '0;
      cnt_q                <= '0;
      frontier_sel         <= 1'b0;
      level_count          <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      incr_traversed_edges <= 1'b0;
    end else begin
      start_q              <= start;
      // Gated by the registered busy, so a pulse in the FIN cycle is still forwarded.
      incr_traversed_edges <= eng_if.eng_edge_visited & busy;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            node_q       <= start_node_address;
            base_q       <= graph_base_address;
            done         <= 1'b0;
            error        <= 1'b0;
            level_count  <= '0;
            frontier_sel <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_LVL_WAIT: if (eng_if.eng_op_done) cnt_q <= eng_if.eng_next_frontier_cnt;
        S_CHECK: begin
          level_count  <= lvl_inc;
          frontier_sel <= ~frontier_sel;
          if (cap_hit) error <= 1'b1;
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
      if (timeout_hit) error <= 1'b1;
    end
  end

  assign eng_if.eng_cmd_valid    = cmd_valid;
  assign eng_if.eng_cmd_op       = cmd_op;
  assign eng_if.eng_cmd_node     = (state == S_INIT_CMD) ? node_q : '0;
  assign eng_if.eng_cmd_base     = base_q;
  assign eng_if.eng_cmd_level    = level_count;
  assign eng_if.eng_frontier_sel = frontier_sel;

endmodule
